// File: rtl/game_ctrl_if.sv
// -----------------------------------------------------------------------------
// game_ctrl_if
//
// Signal bundle between the keyboard/game side and the game-flow controller.
//
//   key_valid  : one-cycle strobe, a key event is present on key_code/key_make
//   key_code   : 9-bit scan code, bit 8 is the extended (E0) flag
//   key_make   : 1 = press, 0 = release (qualified by key_valid)
//   slime_die  : player died (level or pulse) from the game logic
//   screen     : 0 COVER, 1 PLAY, 2 PAUSE, 3 OVER (VGA mux select)
//   run        : high only in PLAY, gates game-logic updates
//   game_rst   : one-cycle pulse when a new game starts
//   move       : one-cycle pulse, 2'b10 left, 2'b01 right, 2'b00 none
//
// master : the keyboard decoder / game logic side (drives key and die inputs)
// slave  : the controller (drives screen, run, game_rst, move)
// -----------------------------------------------------------------------------
interface game_ctrl_if;
  logic       key_valid;
  logic [8:0] key_code;
  logic       key_make;
  logic       slime_die;
  logic [1:0] screen;
  logic       run;
  logic       game_rst;
  logic [1:0] move;

  modport master (
    output key_valid, key_code, key_make, slime_die,
    input  screen, run, game_rst, move
  );

  modport slave (
    input  key_valid, key_code, key_make, slime_die,
    output screen, run, game_rst, move
  );
endinterface

// File: rtl/game_ctrl.sv
// -----------------------------------------------------------------------------
// game_ctrl
//
// Game-flow controller between the PS/2 key decoder and the game logic.
// Tracks the held left/right keys, turns them into one-cycle move pulses with
// key-hold auto-repeat, and runs the cover / play / pause / game-over flow.
//
// Ports:
//   clk  : system clock
//   rst  : asynchronous, active-high reset
//   bus  : game_ctrl_if.slave
//            in : key_valid, key_code[8:0], key_make, slime_die
//            out: screen[1:0], run, game_rst, move[1:0]  (all registered)
//
// Parameters:
//   KEY_LEFT / KEY_RIGHT / KEY_START / KEY_START_ALT / KEY_PAUSE : scan codes
//   REPEAT_DELAY  : cycles from a direction make to the first repeat pulse
//   REPEAT_PERIOD : cycles between later repeat pulses (>= 1)
//   OVER_HOLD     : cycles the game-over screen is shown
//   CNT_W         : counter width, must hold the largest cycle parameter
// -----------------------------------------------------------------------------
module game_ctrl #(
  parameter logic [8:0]  KEY_LEFT      = 9'h01C,
  parameter logic [8:0]  KEY_RIGHT     = 9'h023,
  parameter logic [8:0]  KEY_START     = 9'h05A,
  parameter logic [8:0]  KEY_START_ALT = 9'h15A,
  parameter logic [8:0]  KEY_PAUSE     = 9'h04D,
  parameter int unsigned REPEAT_DELAY  = 12_500_000,
  parameter int unsigned REPEAT_PERIOD = 5_000_000,
  parameter int unsigned OVER_HOLD     = 100_000_000,
  parameter int unsigned CNT_W         = 27
) (
  input  logic        clk,
  input  logic        rst,
  game_ctrl_if.slave  bus
);

  // State encoding doubles as the screen-select code.
  typedef enum logic [1:0] {
    ST_COVER = 2'd0,
    ST_PLAY  = 2'd1,
    ST_PAUSE = 2'd2,
    ST_OVER  = 2'd3
  } state_e;

  // Direction encoding doubles as the move output code.
  typedef enum logic [1:0] {
    DIR_NONE  = 2'b00,
    DIR_RIGHT = 2'b01,
    DIR_LEFT  = 2'b10
  } dir_e;

  // Repeat counter value at which a pulse fires, and the value it reloads to
  // afterwards so the following pulse comes REPEAT_PERIOD cycles later.
  localparam logic [CNT_W-1:0] REP_FIRE   = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] REP_RELOAD = CNT_W'(REPEAT_DELAY - REPEAT_PERIOD);
  localparam logic [CNT_W-1:0] OVER_LAST  = CNT_W'(OVER_HOLD - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  // ---------------------------------------------------------------------------
  // Registered state
  // ---------------------------------------------------------------------------
  state_e           state,      state_n;
  logic             left_held,  left_held_n;
  logic             right_held, right_held_n;
  dir_e             last_dir,   last_dir_n;
  logic [CNT_W-1:0] rep_cnt,    rep_cnt_n;
  logic [CNT_W-1:0] over_cnt,   over_cnt_n;
  logic             run_q,      run_n;
  logic             game_rst_q, game_rst_n;
  dir_e             move_q,     move_n;

  // ---------------------------------------------------------------------------
  // Key event decode
  // ---------------------------------------------------------------------------
  logic ev_left;
  logic ev_right;
  logic make_left;
  logic make_right;
  logic make_start;
  logic make_pause;

  assign ev_left    = bus.key_valid && (bus.key_code == KEY_LEFT);
  assign ev_right   = bus.key_valid && (bus.key_code == KEY_RIGHT);
  assign make_left  = ev_left  && bus.key_make;
  assign make_right = ev_right && bus.key_make;
  assign make_start = bus.key_valid && bus.key_make &&
                      ((bus.key_code == KEY_START) || (bus.key_code == KEY_START_ALT));
  assign make_pause = bus.key_valid && bus.key_make && (bus.key_code == KEY_PAUSE);

  // Active direction: the most recently pressed key wins while it is held,
  // otherwise fall back to the other key if that one is still down.
  function automatic dir_e pick_dir(input logic l, input logic r, input dir_e last);
    dir_e d;
    d = DIR_NONE;
    if      (last == DIR_LEFT  && l) d = DIR_LEFT;
    else if (last == DIR_RIGHT && r) d = DIR_RIGHT;
    else if (l)                      d = DIR_LEFT;
    else if (r)                      d = DIR_RIGHT;
    return d;
  endfunction

  dir_e active_cur;
  dir_e active_nxt;

  // ---------------------------------------------------------------------------
  // Next-state and output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a value before any branch, so no path through
    // this block leaves one unassigned and no latch can be inferred.
    state_n      = state;
    left_held_n  = left_held;
    right_held_n = right_held;
    last_dir_n   = last_dir;
    rep_cnt_n    = '0;      // counter is parked at 0 outside PLAY
    over_cnt_n   = '0;      // cleared on OVER entry and everywhere else
    move_n       = DIR_NONE;
    game_rst_n   = 1'b0;

    // Held tracking runs in every state, including reset recovery and OVER.
    if (ev_left)  left_held_n  = bus.key_make;
    if (ev_right) right_held_n = bus.key_make;
    if (make_left)       last_dir_n = DIR_LEFT;
    else if (make_right) last_dir_n = DIR_RIGHT;

    active_cur = pick_dir(left_held,   right_held,   last_dir);
    active_nxt = pick_dir(left_held_n, right_held_n, last_dir_n);

    unique case (state)
      ST_COVER: begin
        if (make_start) begin
          state_n    = ST_PLAY;
          game_rst_n = 1'b1;
        end
      end

      ST_PLAY: begin
        if (bus.slime_die) begin
          // Death beats every key, including a simultaneous direction make.
          state_n = ST_OVER;
        end else if (make_pause) begin
          // A repeat pulse due on this edge is dropped with the pause.
          state_n = ST_PAUSE;
        end else if (make_left || make_right) begin
          move_n    = make_left ? DIR_LEFT : DIR_RIGHT;
          rep_cnt_n = '0;
        end else if (active_nxt == DIR_NONE) begin
          rep_cnt_n = '0;
        end else if (active_nxt != active_cur) begin
          // A release handed control to the other held key: restart the
          // delay without an immediate pulse.
          rep_cnt_n = '0;
        end else if (rep_cnt == REP_FIRE) begin
          move_n    = active_nxt;
          rep_cnt_n = REP_RELOAD;
        end else begin
          rep_cnt_n = rep_cnt + CNT_ONE;
        end
      end

      ST_PAUSE: begin
        if (make_pause || make_start) state_n = ST_PLAY;
      end

      ST_OVER: begin
        if (over_cnt == OVER_LAST) state_n    = ST_COVER;
        else                       over_cnt_n = over_cnt + CNT_ONE;
      end

      default: state_n = ST_COVER;
    endcase

    run_n = (state_n == ST_PLAY);
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: reset is asynchronous so the screen returns to COVER and any pending
  // move or game_rst pulse is killed immediately, without waiting for a clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_COVER;
      left_held  <= 1'b0;
      right_held <= 1'b0;
      last_dir   <= DIR_NONE;
      rep_cnt    <= '0;
      over_cnt   <= '0;
      run_q      <= 1'b0;
      game_rst_q <= 1'b0;
      move_q     <= DIR_NONE;
    end else begin
      // NOTE: non-blocking assignments make every register sample the values
      // from before this edge, independent of statement order.
      state      <= state_n;
      left_held  <= left_held_n;
      right_held <= right_held_n;
      last_dir   <= last_dir_n;
      rep_cnt    <= rep_cnt_n;
      over_cnt   <= over_cnt_n;
      run_q      <= run_n;
      game_rst_q <= game_rst_n;
      move_q     <= move_n;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs (straight from flops)
  // ---------------------------------------------------------------------------
  assign bus.screen   = state;
  assign bus.run      = run_q;
  assign bus.game_rst = game_rst_q;
  assign bus.move     = move_q;

endmodule

// File: tb/tb_game_ctrl.sv
// -----------------------------------------------------------------------------
// tb_game_ctrl
//
// Self-checking bench for game_ctrl with short timing parameters. A reference
// model tracks the game in absolute cycle numbers (time of next repeat pulse,
// time the game-over screen ends) and is compared with every output after
// every clock edge; directed steps add explicit expectations on top.
// -----------------------------------------------------------------------------
module tb_game_ctrl;

  localparam logic [8:0] K_LEFT      = 9'h01C;
  localparam logic [8:0] K_RIGHT     = 9'h023;
  localparam logic [8:0] K_START     = 9'h05A;
  localparam logic [8:0] K_START_ALT = 9'h15A;
  localparam logic [8:0] K_PAUSE     = 9'h04D;
  localparam int DELAY  = 8;
  localparam int PERIOD = 4;
  localparam int HOLD   = 16;

  logic clk;
  logic rst;

  game_ctrl_if bus ();

  game_ctrl #(
    .KEY_LEFT      (K_LEFT),
    .KEY_RIGHT     (K_RIGHT),
    .KEY_START     (K_START),
    .KEY_START_ALT (K_START_ALT),
    .KEY_PAUSE     (K_PAUSE),
    .REPEAT_DELAY  (DELAY),
    .REPEAT_PERIOD (PERIOD),
    .OVER_HOLD     (HOLD),
    .CNT_W         (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model (screen codes 0 cover, 1 play, 2 pause, 3 over;
  // directions 2 left, 1 right, 0 none)
  // ---------------------------------------------------------------------------
  int     m_state;
  bit     m_l, m_r;
  int     m_last;
  longint cyc, next_fire, over_end;
  int     e_move;
  bit     e_grst;

  function automatic int active_of(input bit l, input bit r, input int last);
    if (last == 2 && l) return 2;
    if (last == 1 && r) return 1;
    if (l) return 2;
    if (r) return 1;
    return 0;
  endfunction

  task automatic model_reset();
    m_state = 0; m_l = 0; m_r = 0; m_last = 0;
    e_move = 0; e_grst = 0; next_fire = 0; over_end = 0;
  endtask

  task automatic model_step(input bit v, input logic [8:0] c, input bit mk, input bit die);
    int prev, now;
    bit mk_l, mk_r, mk_start, mk_pause;
    cyc++;
    prev     = active_of(m_l, m_r, m_last);
    mk_l     = v && mk && c == K_LEFT;
    mk_r     = v && mk && c == K_RIGHT;
    mk_start = v && mk && (c == K_START || c == K_START_ALT);
    mk_pause = v && mk && c == K_PAUSE;
    if (v && c == K_LEFT)  m_l = mk;
    if (v && c == K_RIGHT) m_r = mk;
    if (mk_l) m_last = 2; else if (mk_r) m_last = 1;
    now    = active_of(m_l, m_r, m_last);
    e_move = 0;
    e_grst = 0;
    case (m_state)
      0: if (mk_start) begin m_state = 1; e_grst = 1; next_fire = cyc + DELAY; end
      1: begin
        if (die) begin
          m_state = 3; over_end = cyc + HOLD;
        end else if (mk_pause) begin
          m_state = 2;
        end else if (mk_l || mk_r) begin
          e_move = mk_l ? 2 : 1; next_fire = cyc + DELAY;
        end else if (now != 0) begin
          if (now != prev) next_fire = cyc + DELAY;
          else if (cyc == next_fire) begin e_move = now; next_fire = cyc + PERIOD; end
        end
      end
      2: if (mk_pause || mk_start) begin m_state = 1; next_fire = cyc + DELAY; end
      default: if (cyc == over_end) m_state = 0;
    endcase
  endtask

  // One clock: drive inputs, step through the edge, compare 1 time unit later.
  task automatic tick(input bit v, input logic [8:0] c, input bit mk, input bit die);
    bus.key_valid = v;
    bus.key_code  = c;
    bus.key_make  = mk;
    bus.slime_die = die;
    @(posedge clk);
    #1;
    model_step(v, c, mk, die);
    check("screen",   32'(bus.screen),   32'(m_state));
    check("run",      32'(bus.run),      32'(m_state == 1));
    check("game_rst", 32'(bus.game_rst), 32'(e_grst));
    check("move",     32'(bus.move),     32'(e_move));
    bus.key_valid = 1'b0;
    bus.slime_die = 1'b0;
  endtask

  task automatic idle();
    tick(1'b0, 9'h000, 1'b0, 1'b0);
  endtask

  // Called 1 time unit after an edge: reset pulse entirely between edges.
  task automatic async_reset(input string tag);
    #2 rst = 1'b1;
    #1;
    check({tag, "_screen"},   32'(bus.screen),   32'd0);
    check({tag, "_move"},     32'(bus.move),     32'd0);
    check({tag, "_run"},      32'(bus.run),      32'd0);
    check({tag, "_game_rst"}, 32'(bus.game_rst), 32'd0);
    model_reset();
    #2 rst = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic [8:0] rc;
    rst = 1'b1;
    bus.key_valid = 1'b0;
    bus.key_code  = '0;
    bus.key_make  = 1'b0;
    bus.slime_die = 1'b0;
    cyc = 0;
    model_reset();

    #12;
    check("rst_screen",   32'(bus.screen),   32'd0);
    check("rst_run",      32'(bus.run),      32'd0);
    check("rst_game_rst", 32'(bus.game_rst), 32'd0);
    check("rst_move",     32'(bus.move),     32'd0);
    rst = 1'b0;

    // Start from COVER with Enter, then with keypad Enter.
    tick(1, K_START, 1, 0);
    check("start_screen", 32'(bus.screen), 32'd1);
    check("start_run",    32'(bus.run),    32'd1);
    check("start_grst",   32'(bus.game_rst), 32'd1);
    idle();
    check("start_grst_off", 32'(bus.game_rst), 32'd0);
    async_reset("rst2");
    tick(1, K_START_ALT, 1, 0);
    check("alt_screen", 32'(bus.screen), 32'd1);
    check("alt_grst",   32'(bus.game_rst), 32'd1);
    idle();

    // Hold left: pulses at cycles 1, 9, 13, 17; break at cycle 20.
    tick(1, K_LEFT, 1, 0);
    check("hold_left_1", 32'(bus.move), 32'd2);
    for (int k = 2; k <= 19; k++) begin
      idle();
      check("hold_left", 32'(bus.move), (k == 9 || k == 13 || k == 17) ? 32'd2 : 32'd0);
    end
    tick(1, K_LEFT, 0, 0);
    for (int k = 0; k < 10; k++) begin
      idle();
      check("after_break", 32'(bus.move), 32'd0);
    end

    // Left held, right pressed then released: left resumes after the delay.
    tick(1, K_LEFT, 1, 0);
    repeat (3) idle();
    tick(1, K_RIGHT, 1, 0);
    check("right_make", 32'(bus.move), 32'd1);
    repeat (2) idle();
    tick(1, K_RIGHT, 0, 0);
    check("right_break", 32'(bus.move), 32'd0);
    for (int j = 1; j <= 8; j++) begin
      idle();
      check("left_resume", 32'(bus.move), (j == 8) ? 32'd2 : 32'd0);
    end
    tick(1, K_LEFT, 0, 0);

    // Pause: no moves while paused, resume without game_rst.
    tick(1, K_PAUSE, 1, 0);
    check("pause_screen", 32'(bus.screen), 32'd2);
    check("pause_run",    32'(bus.run),    32'd0);
    tick(1, K_LEFT, 1, 0);
    check("pause_move", 32'(bus.move), 32'd0);
    for (int k = 0; k < 10; k++) begin
      idle();
      check("pause_quiet", 32'(bus.move), 32'd0);
    end
    tick(1, K_PAUSE, 1, 0);
    check("resume_screen", 32'(bus.screen), 32'd1);
    check("resume_grst",   32'(bus.game_rst), 32'd0);
    repeat (10) idle();
    tick(1, K_LEFT, 0, 0);

    // Death beats pause; OVER lasts 16 cycles and ignores start.
    tick(1, K_PAUSE, 1, 1);
    check("die_screen", 32'(bus.screen), 32'd3);
    for (int j = 1; j <= 16; j++) begin
      if (j == 5) tick(1, K_START, 1, 0);
      else        idle();
      check("over_hold", 32'(bus.screen), (j < 16) ? 32'd3 : 32'd0);
    end

    // Direction make together with death: no pulse.
    tick(1, K_START, 1, 0);
    tick(1, K_RIGHT, 1, 1);
    check("die_dir_move",   32'(bus.move),   32'd0);
    check("die_dir_screen", 32'(bus.screen), 32'd3);
    tick(1, K_RIGHT, 0, 0);
    repeat (16) idle();
    check("over_done", 32'(bus.screen), 32'd0);

    // Reset mid-repeat, right after a repeat pulse appears.
    tick(1, K_START, 1, 0);
    tick(1, K_LEFT, 1, 0);
    repeat (7) idle();
    idle();
    check("pre_reset_pulse", 32'(bus.move), 32'd2);
    async_reset("mid_rst");

    // Randomised traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      case ($urandom_range(0, 7))
        0, 1:    rc = K_LEFT;
        2, 3:    rc = K_RIGHT;
        4:       rc = K_START;
        5:       rc = K_START_ALT;
        6:       rc = K_PAUSE;
        default: rc = 9'($urandom_range(0, 511));
      endcase
      tick($urandom_range(0, 3) == 0, rc, $urandom_range(0, 2) != 0,
           $urandom_range(0, 79) == 0);
      if ($urandom_range(0, 999) == 0) async_reset("rand_rst");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/game_ctrl.md
# game_ctrl

Parametrised game-flow controller sitting between the PS/2 keyboard decoder and the game logic (slime, floor generator, pixel generators). It tracks held direction keys, turns them into move pulses with auto-repeat, and runs a four-state game FSM (cover / play / pause / game-over). It drives the screen-select code for the VGA output mux, a one-cycle game-reset pulse and a run enable. It generalises the single-step cover/game logic with parametrised key codes, pause, a timed game-over screen and key-hold auto-repeat.

## Interface
Parameters:
- KEY_LEFT, 9'h01C, scan code for move left (A)
- KEY_RIGHT, 9'h023, scan code for move right (D)
- KEY_START, 9'h05A, scan code for start (Enter)
- KEY_START_ALT, 9'h15A, alternate start code (keypad Enter)
- KEY_PAUSE, 9'h04D, scan code for pause toggle (P)
- REPEAT_DELAY, 12_500_000, cycles from key make to first repeat pulse
- REPEAT_PERIOD, 5_000_000, cycles between later repeat pulses; must be ≥1
- OVER_HOLD, 100_000_000, cycles spent in OVER before returning to COVER
- CNT_W, 27, counter width; must hold the largest of the three cycle parameters

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- key_valid  in  1  one-cycle strobe: a new key event is present
- key_code  in  9  scan code of the event; bit 8 is the extended (E0) flag
- key_make  in  1  1 = press, 0 = release; sampled with key_valid
- slime_die  in  1  level/pulse from game logic: player died
- screen  out  2  0 COVER, 1 PLAY, 2 PAUSE, 3 OVER
- run  out  1  high only in PLAY; gates game-logic updates
- game_rst  out  1  one-cycle pulse on COVER→PLAY
- move  out  2  one-cycle pulse: 2'b10 left, 2'b01 right, else 2'b00

## Operation
- Held tracking, in every state: left_held and right_held are set on a make of their code and cleared on a break. last_dir records the direction of the most recent make.
- Active direction: last_dir if it is still held, else the other direction if it is held, else none.
- FSM:
  - COVER: a make of KEY_START or KEY_START_ALT → PLAY, with game_rst pulsed.
  - PLAY: slime_die → OVER. Otherwise a make of KEY_PAUSE → PAUSE.
  - PAUSE: a make of KEY_PAUSE, KEY_START or KEY_START_ALT → PLAY; game_rst is not pulsed. slime_die is ignored.
  - OVER: the hold counter runs from 0. On reaching OVER_HOLD-1 → COVER. All keys are ignored.
- Move generation, only in PLAY:
  - A make of a direction key gives an immediate pulse of that direction and clears the repeat counter.
  - While an active direction exists, the repeat counter increments. A pulse fires when it reaches REPEAT_DELAY-1, then every REPEAT_PERIOD cycles.
  - A change of active direction caused by a release restarts the counter without an immediate pulse.
  - No active direction clears the counter.
- Outside PLAY, move = 00 and the repeat counter is held at 0; held tracking continues.
- Break codes never change FSM state.
- screen = state encoding; run = (state == PLAY).

## Timing
- All outputs are registered; latency is 1 cycle from the key_valid/slime_die edge to the state, screen, game_rst or move change.
- Reset (asynchronous, immediate):
  - state = COVER, screen = 0, run = 0, game_rst = 0, move = 00.
  - held flags and last_dir cleared; all counters = 0.
- Reset asserted mid-game or mid-repeat returns to COVER with no move or game_rst pulse emitted.
- Simultaneous events in PLAY:
  - slime_die beats KEY_PAUSE: go to OVER, no move pulse.
  - A direction make together with slime_die: no pulse.
- The move pulse issued on the same edge as entering PAUSE is suppressed.
- The OVER counter is cleared on entry; OVER lasts exactly OVER_HOLD cycles.
- Counters never wrap: the repeat counter reloads to REPEAT_DELAY-REPEAT_PERIOD after each repeat pulse, so the next pulse comes REPEAT_PERIOD later.

## Test plan
Run the bench with REPEAT_DELAY=8, REPEAT_PERIOD=4, OVER_HOLD=16, CNT_W=8.
- Reset, then a make of 9'h05A → next cycle screen=1, run=1, game_rst=1 for exactly 1 cycle; a make of 9'h15A from COVER behaves the same.
- In PLAY, make 9'h01C and hold 20 cycles → move=10 at cycles 1, 9, 13, 17 after the event; after the break, move stays 00.
- Hold left, then make right, then release right → right pulse immediately; after the right release, left pulses 8 cycles later with no immediate pulse.
- In PLAY, make 9'h04D → screen=2, run=0, no moves; a make of 9'h04D again → screen=1 with no game_rst.
- In PLAY, slime_die together with a make of 9'h04D → screen=3; after 16 cycles screen=0; a make of 9'h05A during OVER is ignored.
- Assert rst mid-repeat in PLAY → screen=0 and move=00 immediately, before the next clk edge.
